erx_rrbuf: RTL and testbench
============================

ERX_RRBUF -- requirements
Module: erx_rrbuf

Interface
REQ-001 SHALL have parameter AW, default 32, address width; localparam PW = 2*AW+40, packet width.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffer entries, a power of two and at least 4.
REQ-003 SHALL have localparam CW = log2(DEPTH)+1, occupancy counter width.
REQ-004 SHALL have port clk, input, 1, the single block clock.
REQ-005 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ecfg_access, input, 1, valid readback response from the erx config stage.
REQ-007 SHALL have port ecfg_packet, input, PW, readback response packet.
REQ-008 SHALL have port ecfg_wait, output, 1, pushback to the config-request source.
REQ-009 SHALL have port rr_access, output, 1, buffered response valid toward the read-response channel.
REQ-010 SHALL have port rr_packet, output, PW, buffered response packet.
REQ-011 SHALL have port rr_wait, input, 1, stall from the read-response channel.
REQ-012 SHALL have port clear, input, 1, synchronous pulse that clears overflow and rr_total.
REQ-013 SHALL have port overflow, output, 1, sticky flag marking that a response was dropped.
REQ-014 SHALL have port rr_count, output, CW, current occupancy.
REQ-015 SHALL have port rr_total, output, 16, number of responses delivered, saturating.

Function
REQ-016 SHALL be a first-word-fall-through FIFO of DEPTH x PW entries with registered read/write pointers and an occupancy counter.
REQ-017 SHALL push when ecfg_access=1 and (count<DEPTH or pop=1); the packet is stored at the clock edge.
REQ-018 SHALL define pop = rr_access & ~rr_wait.
REQ-019 SHALL set rr_access = (count!=0), with rr_packet equal to the entry at the read pointer, driven combinationally from the registered state.
REQ-020 SHALL give a push-to-output latency of exactly 1 cycle: a packet pushed at edge N appears on rr_access/rr_packet after edge N when the buffer was empty.
REQ-021 SHALL hold rr_packet stable while rr_access=1 and rr_wait=1.
REQ-022 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers, including when count=DEPTH.
REQ-023 SHALL wrap pointers modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.
REQ-024 SHALL assert ecfg_wait = (count >= DEPTH-2), combinationally from count, giving a two-slot skid for the one-cycle-pipelined upstream.
REQ-025 SHALL drop ecfg_packet when ecfg_access=1, count=DEPTH and pop=0, leaving the stored contents and pointers unchanged.
REQ-026 SHALL register overflow=1 on the edge following a dropped push; overflow SHALL hold until clear.
REQ-027 SHALL give set priority over clear when a drop and clear occur in the same cycle.
REQ-028 SHALL increment rr_total on each pop, saturate at 0xFFFF, and reset to 0 on clear; on clear together with pop, rr_total SHALL become 0.
REQ-029 SHALL drive rr_count as the registered occupancy.
REQ-030 SHALL leave pointers and contents unaffected by clear.

Reset
REQ-031 SHALL, while nreset=0, asynchronously force count=0, both pointers=0, overflow=0 and rr_total=0, giving rr_access=0 and ecfg_wait=0.
REQ-032 SHALL not reset the storage array; rr_packet is don't-care while rr_access=0.
REQ-033 SHALL discard all buffered entries on reset mid-operation and accept no push until the first edge after nreset deasserts.

Verification (DEPTH=4, AW=32)
REQ-034 SHALL verify: single push of packet P1 with rr_wait=0 -> rr_access=1 for exactly one cycle, one cycle after the push, with rr_packet=P1, rr_total=1 and rr_count returning to 0.
REQ-035 SHALL verify: rr_wait=1 with pushes P1..P4 on consecutive cycles -> ecfg_wait rises after the 2nd push, rr_count=4, overflow=0, rr_packet held at P1.
REQ-036 SHALL verify: the buffer full with rr_wait=1 and a 5th push P5 -> P5 dropped, overflow=1 next cycle, and releasing rr_wait drains P1..P4 in order.
REQ-037 SHALL verify: the buffer full with push P5 and pop in the same cycle -> rr_count stays 4, and the drain order is P2, P3, P4, P5 with no overflow.
REQ-038 SHALL verify: clear asserted in the same cycle as a dropped push -> overflow=1 and rr_total=0; clear alone on the next cycle -> overflow=0.
REQ-039 SHALL verify: nreset pulsed low with rr_count=3 -> rr_access=0, rr_count=0 and ecfg_wait=0 immediately, and the first subsequent push emerges after 1 cycle with the pointers at 0.

Source files
------------

// File: rtl/erx_rrbuf.sv
// rtl/erx_rrbuf.sv - erx read-response buffer
// FWFT FIFO between the config readback stage and the read-response channel.
module erx_rrbuf #(
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  localparam int PW   = 2*AW+40,
  localparam int CW   = $clog2(DEPTH)+1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          ecfg_access,
  input  logic [PW-1:0] ecfg_packet,
  output logic          ecfg_wait,
  output logic          rr_access,
  output logic [PW-1:0] rr_packet,
  input  logic          rr_wait,
  input  logic          clear,
  output logic          overflow,
  output logic [CW-1:0] rr_count,
  output logic [15:0]   rr_total
);

  localparam int PTRW = $clog2(DEPTH);

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wptr;
  logic [PTRW-1:0] rptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign full      = (count == CW'(DEPTH));
  assign rr_access = (count != '0);
  assign rr_packet = mem[rptr];
  assign pop       = rr_access & ~rr_wait;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push      = ecfg_access & (~full | pop);
  assign drop      = ecfg_access & full & ~pop;
  // Two free slots cover the responses already in flight from the upstream pipe.
  assign ecfg_wait = (count >= CW'(DEPTH-2));
  assign rr_count  = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= ecfg_packet;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTRW'(1);
      end
      if (pop) begin
        rptr <= rptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_total <= '0;
    end else if (clear) begin
      rr_total <= '0;
    end else if (pop && (rr_total != 16'hFFFF)) begin
      rr_total <= rr_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_erx_rrbuf.sv
// tb/tb_erx_rrbuf.sv - self-checking bench for erx_rrbuf
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_erx_rrbuf;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2*AW+40;
  localparam int CW    = $clog2(DEPTH)+1;

  logic          clk = 1'b0;
  logic          nreset;
  logic          ecfg_access;
  logic [PW-1:0] ecfg_packet;
  logic          ecfg_wait;
  logic          rr_access;
  logic [PW-1:0] rr_packet;
  logic          rr_wait;
  logic          clear;
  logic          overflow;
  logic [CW-1:0] rr_count;
  logic [15:0]   rr_total;

  int passed = 0;
  int total  = 0;

  erx_rrbuf #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .ecfg_access(ecfg_access), .ecfg_packet(ecfg_packet), .ecfg_wait(ecfg_wait),
    .rr_access(rr_access), .rr_packet(rr_packet), .rr_wait(rr_wait),
    .clear(clear), .overflow(overflow), .rr_count(rr_count), .rr_total(rr_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [PW-1:0] pk(input int i);
    return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 40'(i * 7 + 3)};
  endfunction

  // Reference model: a bounded queue plus sticky flag and saturating counter.
  logic [PW-1:0] mq[$];
  bit            m_ov;
  int            m_tot;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mq.delete();
      m_ov  = 1'b0;
      m_tot = 0;
    end else begin
      bit do_pop, is_full;
      do_pop  = (mq.size() != 0) && !rr_wait;
      is_full = (mq.size() == DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (ecfg_access) begin
        if (!is_full || do_pop) mq.push_back(ecfg_packet);
        else m_ov = 1'b1;
      end
      if (clear) begin
        if (!(ecfg_access && is_full && !do_pop)) m_ov = 1'b0;
        m_tot = 0;
      end else if (do_pop && m_tot < 16'hFFFF) begin
        m_tot++;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_access", 128'(rr_access), 128'(mq.size() != 0));
    if (mq.size() != 0) chk("m_packet", 128'(rr_packet), 128'(mq[0]));
    chk("m_count", 128'(rr_count), 128'(mq.size()));
    chk("m_wait", 128'(ecfg_wait), 128'(mq.size() >= DEPTH-2));
    chk("m_overflow", 128'(overflow), 128'(m_ov));
    chk("m_total", 128'(rr_total), 128'(m_tot));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) begin
      ecfg_access = 1'b1;
      ecfg_packet = pk(i);
      tick();
    end
    ecfg_access = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0; ecfg_access = 1'b0; ecfg_packet = '0; rr_wait = 1'b0; clear = 1'b0;
    repeat (3) tick();
    chk("rst_access", 128'(rr_access), 128'd0);
    chk("rst_count", 128'(rr_count), 128'd0);
    chk("rst_wait", 128'(ecfg_wait), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_total", 128'(rr_total), 128'd0);
    nreset = 1'b1;
    tick();

    // Single push, no backpressure.
    ecfg_access = 1'b1; ecfg_packet = pk(1);
    tick();
    ecfg_access = 1'b0;
    chk("s1_access", 128'(rr_access), 128'd1);
    chk("s1_packet", 128'(rr_packet), 128'(pk(1)));
    chk("s1_count", 128'(rr_count), 128'd1);
    tick();
    chk("s1_access_off", 128'(rr_access), 128'd0);
    chk("s1_total", 128'(rr_total), 128'd1);
    chk("s1_count0", 128'(rr_count), 128'd0);

    // Stalled fill of four.
    rr_wait = 1'b1;
    ecfg_access = 1'b1; ecfg_packet = pk(1);
    tick();
    chk("s2_wait1", 128'(ecfg_wait), 128'd0);
    ecfg_packet = pk(2);
    tick();
    chk("s2_wait2", 128'(ecfg_wait), 128'd1);
    ecfg_packet = pk(3);
    tick();
    ecfg_packet = pk(4);
    tick();
    ecfg_access = 1'b0;
    chk("s2_count", 128'(rr_count), 128'd4);
    chk("s2_overflow", 128'(overflow), 128'd0);
    chk("s2_packet", 128'(rr_packet), 128'(pk(1)));

    // Fifth push while full and stalled is dropped.
    ecfg_access = 1'b1; ecfg_packet = pk(5);
    tick();
    ecfg_access = 1'b0;
    chk("s3_overflow", 128'(overflow), 128'd1);
    chk("s3_count", 128'(rr_count), 128'd4);
    rr_wait = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("s3_drain", 128'(rr_packet), 128'(pk(i)));
      tick();
    end
    chk("s3_empty", 128'(rr_access), 128'd0);
    chk("s3_total", 128'(rr_total), 128'd5);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_overflow", 128'(overflow), 128'd0);
    chk("clr_total", 128'(rr_total), 128'd0);

    // Full buffer: push and pop in the same cycle.
    rr_wait = 1'b1;
    fill4();
    rr_wait = 1'b0; ecfg_access = 1'b1; ecfg_packet = pk(5);
    tick();
    ecfg_access = 1'b0;
    chk("s4_count", 128'(rr_count), 128'd4);
    chk("s4_overflow", 128'(overflow), 128'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("s4_drain", 128'(rr_packet), 128'(pk(i)));
      tick();
    end
    chk("s4_total", 128'(rr_total), 128'd5);

    // Drop and clear together: set wins, then clear alone.
    rr_wait = 1'b1;
    fill4();
    ecfg_access = 1'b1; ecfg_packet = pk(9); clear = 1'b1;
    tick();
    ecfg_access = 1'b0;
    chk("s5_overflow", 128'(overflow), 128'd1);
    chk("s5_total", 128'(rr_total), 128'd0);
    tick();
    clear = 1'b0;
    chk("s5_clear", 128'(overflow), 128'd0);

    // Reset mid-operation at occupancy 3.
    rr_wait = 1'b0;
    tick();
    rr_wait = 1'b1;
    chk("s6_count3", 128'(rr_count), 128'd3);
    ecfg_access = 1'b1; ecfg_packet = pk(6);
    nreset = 1'b0;
    #1;
    chk("s6_access", 128'(rr_access), 128'd0);
    chk("s6_count", 128'(rr_count), 128'd0);
    chk("s6_wait", 128'(ecfg_wait), 128'd0);
    tick();
    chk("s6_held", 128'(rr_count), 128'd0);
    nreset = 1'b1; rr_wait = 1'b0;
    tick();
    ecfg_access = 1'b0;
    chk("s6_access1", 128'(rr_access), 128'd1);
    chk("s6_packet", 128'(rr_packet), 128'(pk(6)));
    chk("s6_count1", 128'(rr_count), 128'd1);
    tick();
    chk("s6_total", 128'(rr_total), 128'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
